// File: rtl/hex_scan_display.sv
// Time-multiplexed hex display driver: scans NUM_DIGITS common-anode digits from a tear-free shadow register.
// Optional feature: define HEX_LEADING_ZERO_BLANK_EN to blank digits above the most significant nonzero nibble.
module hex_scan_display #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 12000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [4*NUM_DIGITS-1:0] DATA,
    input  logic                    LOAD,
    output logic                    ACK,
    output logic [6:0]              SEG,
    output logic [NUM_DIGITS-1:0]   COMM,
    output logic                    FRAME
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYCLES);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

    // LOAD/ACK handshake: the source holds LOAD and DATA stable until ACK; DATA is
    // taken only on the edge where the digit index wraps to 0, and ACK pulses once
    // in the following cycle. A request not met at a boundary simply stays pending.

    logic [SW-1:0]           slot_q, slot_d;
    logic [DW-1:0]           digit_q, digit_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   comm_q, comm_d;
    logic                    ack_q, ack_d;
    logic                    frame_q, frame_d;
    logic                    slot_wrap;
    logic                    frame_wrap;
    logic [3:0]              nibble;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

`ifdef HEX_LEADING_ZERO_BLANK_EN
    logic [DW-1:0] msd;

    // Digit 0 is never a candidate for blanking, so the search starts at 1.
    always_comb begin
        msd = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (shadow_q[4*k +: 4] != 4'h0) msd = DW'(k);
        end
    end
`endif

    always_comb begin
        slot_wrap  = (slot_q == SLOT_LAST);
        frame_wrap = slot_wrap && (digit_q == DIGIT_LAST);
        slot_d     = slot_wrap ? '0 : slot_q + 1'b1;
        digit_d    = digit_q;
        if (slot_wrap) digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
        shadow_d   = shadow_q;
        ack_d      = 1'b0;
        frame_d    = frame_wrap;
        if (frame_wrap && LOAD) begin
            shadow_d = DATA;
            ack_d    = 1'b1;
        end
    end

    always_comb begin
        nibble = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_q == DW'(k)) nibble = shadow_q[4*k +: 4];
        end
        seg_d  = 7'b1111111;
        comm_d = '0;
        if (slot_q >= BLANK_END) begin
            comm_d = NUM_DIGITS'(1) << digit_q;
            seg_d  = hex_to_seg(nibble);
`ifdef HEX_LEADING_ZERO_BLANK_EN
            if (digit_q > msd) seg_d = 7'b1111111;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            slot_q   <= '0;
            digit_q  <= '0;
            shadow_q <= '0;
            seg_q    <= 7'b1111111;
            comm_q   <= '0;
            ack_q    <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            digit_q  <= digit_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            comm_q   <= comm_d;
            ack_q    <= ack_d;
            frame_q  <= frame_d;
        end
    end

    assign SEG   = seg_q;
    assign COMM  = comm_q;
    assign ACK   = ack_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Bench for hex_scan_display: cycle model of the scan plus a queue of expected captures,
// each confirmed by ACK and by the digits decoded back from the following full frame.
module tb_hex_scan_display;

    localparam int ND        = 4;
    localparam int SD        = 8;
    localparam int BC        = 2;
    localparam int FRAME_LEN = ND * SD;

    logic        CLK = 1'b0;
    logic        RST;
    logic        LOAD;
    logic [15:0] DATA;
    logic        ACK;
    logic        FRAME;
    logic [6:0]  SEG;
    logic [3:0]  COMM;

    hex_scan_display #(
        .NUM_DIGITS(ND),
        .SCAN_DIV(SD),
        .BLANK_CYCLES(BC)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .DATA(DATA),
        .LOAD(LOAD),
        .ACK(ACK),
        .SEG(SEG),
        .COMM(COMM),
        .FRAME(FRAME)
    );

    always #5 CLK = ~CLK;

    logic [6:0] seg_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_q[$];

    int          k_m = 0;
    logic [15:0] shadow_m = '0;
    logic [6:0]  exp_seg = 7'b1111111;
    logic [3:0]  exp_comm = '0;
    logic        exp_ack = 1'b0;
    logic        exp_frame = 1'b0;

    int          t = 0;
    int          last_frame_t = 0;
    bit          last_frame_ok = 1'b0;
    logic [3:0]  disp_obs [4];
    logic [15:0] pend = '0;
    bit          pend_valid = 1'b0;
    bit          ack_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at t=%0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    function automatic logic [3:0] inv_seg(input logic [6:0] s);
        logic [3:0] r;
        r = 4'bxxxx;
        for (int j = 0; j < 16; j++) begin
            if (seg_tbl[j] == s) r = 4'(j);
        end
`ifdef HEX_LEADING_ZERO_BLANK_EN
        if (s == 7'b1111111) r = 4'h0;
`endif
        return r;
    endfunction

`ifdef HEX_LEADING_ZERO_BLANK_EN
    function automatic int top_digit(input logic [15:0] v);
        int top;
        top = 0;
        for (int i = 1; i < ND; i++) begin
            if (v[i*4 +: 4] != 4'h0) top = i;
        end
        return top;
    endfunction
`endif

    // One clock: advance the model on the rising edge, compare pins on the falling edge.
    task automatic tick();
        int          slot;
        int          dig;
        logic [3:0]  nib;
        logic [15:0] disp;
        @(posedge CLK);
        t++;
        if (RST) begin
            k_m        = 0;
            shadow_m   = '0;
            exp_seg    = 7'b1111111;
            exp_comm   = '0;
            exp_ack    = 1'b0;
            exp_frame  = 1'b0;
            exp_q.delete();
            pend_valid    = 1'b0;
            last_frame_ok = 1'b0;
        end else begin
            slot     = k_m % SD;
            dig      = (k_m / SD) % ND;
            exp_seg  = 7'b1111111;
            exp_comm = '0;
            if (slot >= BC) begin
                exp_comm = 4'(1 << dig);
                nib      = shadow_m[dig*4 +: 4];
                exp_seg  = seg_tbl[nib];
`ifdef HEX_LEADING_ZERO_BLANK_EN
                if (dig > top_digit(shadow_m)) exp_seg = 7'b1111111;
`endif
            end
            k_m++;
            exp_frame = (k_m % FRAME_LEN == 0);
            exp_ack   = exp_frame && LOAD;
            if (exp_ack) shadow_m = DATA;
        end
        @(negedge CLK);
        check("seg", SEG, exp_seg);
        check("comm", COMM, exp_comm);
        check("ack", ACK, exp_ack);
        check("frame", FRAME, exp_frame);
        check("comm_onehot0", $onehot0(COMM), 1);
        if (COMM == 4'b0000) check("seg_dark_when_idle", SEG, 7'b1111111);
        for (int d = 0; d < ND; d++) begin
            if (COMM[d]) disp_obs[d] = inv_seg(SEG);
        end
        if (FRAME) begin
            if (last_frame_ok) check("frame_period", t - last_frame_t, FRAME_LEN);
            last_frame_t  = t;
            last_frame_ok = 1'b1;
            if (pend_valid) begin
                disp = {disp_obs[3], disp_obs[2], disp_obs[1], disp_obs[0]};
                check("frame_display", disp, pend);
                pend_valid = 1'b0;
            end
        end
        if (ACK) begin
            ack_seen = 1'b1;
            check("ack_has_request", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                pend       = exp_q.pop_front();
                pend_valid = 1'b1;
            end
        end
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        ack_seen = 1'b0;
        while (!ack_seen && n < 3 * FRAME_LEN) begin
            tick();
            n++;
        end
        check({tag, "_ack_seen"}, ack_seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST  = 1'b1;
        LOAD = 1'b0;
        DATA = '0;
        repeat (3) tick();
        RST = 1'b0;

        // Display 1234 with LOAD held until ACK at the first frame wrap.
        LOAD = 1'b1;
        DATA = 16'h1234;
        exp_q.push_back(16'h1234);
        wait_ack("load_1234");
        LOAD = 1'b0;
        repeat (40) tick();

        // Request mid-frame, DATA changes before the boundary.
        repeat (10) tick();
        LOAD = 1'b1;
        DATA = 16'hABCD;
        repeat (5) tick();
        DATA = 16'hEF01;
        exp_q.push_back(16'hEF01);
        wait_ack("load_ef01");
        LOAD = 1'b0;
        repeat (40) tick();

        // Idle for three frames: no ACK, display unchanged.
        repeat (3 * FRAME_LEN + 4) tick();

        // Reset lands on the boundary edge with a request pending.
        while (k_m % FRAME_LEN != FRAME_LEN - 4) tick();
        LOAD = 1'b1;
        DATA = 16'h5A5A;
        exp_q.push_back(16'h5A5A);
        while (k_m % FRAME_LEN != FRAME_LEN - 1) tick();
        RST = 1'b1;
        tick();
        RST  = 1'b0;
        LOAD = 1'b0;
        pend       = 16'h0000;
        pend_valid = 1'b1;
        repeat (40) tick();

        // Leading-zero case.
        LOAD = 1'b1;
        DATA = 16'h0040;
        exp_q.push_back(16'h0040);
        wait_ack("load_0040");
        LOAD = 1'b0;
        repeat (40) tick();

        // LOAD left high after ACK captures again at the next boundary.
        LOAD = 1'b1;
        DATA = 16'h9876;
        exp_q.push_back(16'h9876);
        exp_q.push_back(16'h9876);
        wait_ack("hold_first");
        wait_ack("hold_second");
        LOAD = 1'b0;
        repeat (40) tick();

        check("queue_drained", exp_q.size(), 0);
        check("display_checked", pend_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hex_scan_display.md
HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 12000, CLK cycles per digit slot (legal >= 2).
REQ-003 SHALL have parameter BLANK_CYCLES, default 16, blanked cycles at the start of each slot (legal 0..SCAN_DIV-1).
REQ-004 SHALL have port CLK  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port DATA  input  4*NUM_DIGITS  hex value to display; nibble k drives digit k, and digit 0 is least significant.
REQ-007 SHALL have port LOAD  input  1  request to capture DATA; held high by the source until ACK.
REQ-008 SHALL have port ACK  output  1  one-cycle pulse confirming capture.
REQ-009 SHALL have port SEG  output  7  segments, active low; bit0=a ... bit6=g.
REQ-010 SHALL have port COMM  output  NUM_DIGITS  digit commons, active high, at most one bit set.
REQ-011 SHALL have port FRAME  output  1  one-cycle pulse when a digit-0 slot begins.

Function
REQ-012 SHALL keep a slot counter (0..SCAN_DIV-1) and a digit index (0..NUM_DIGITS-1); the slot counter increments every cycle and wraps, and the digit index advances on the wrap, going from NUM_DIGITS-1 to 0.
REQ-013 SHALL drive COMM=0 and SEG=7'b1111111 while slot counter < BLANK_CYCLES; otherwise COMM has only bit [digit index] set and SEG shows the decoded nibble.
REQ-014 SHALL register SEG and COMM, giving exactly 1 cycle latency from counter state to pins.
REQ-015 SHALL decode 0..F, with a leading 0 meaning that segment is lit: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
REQ-016 SHALL display from an internal shadow register and never directly from DATA.
REQ-017 SHALL capture DATA into the shadow only on the edge where the digit index wraps to 0 and LOAD=1, so that no frame ever tears.
REQ-018 SHALL assert ACK for exactly the one cycle following a capture, and SHALL hold ACK=0 in all other cycles.
REQ-019 SHALL leave the shadow unchanged if LOAD=0 at the frame boundary, and SHALL keep LOAD pending with no ACK until the next boundary.
REQ-020 SHALL capture again at the next boundary if LOAD stays high after ACK; the source SHALL drop LOAD on ACK.
REQ-021 SHALL pulse FRAME for one cycle coincident with ACK timing, i.e. in the cycle after the digit index wraps to 0, regardless of LOAD.
REQ-022 SHALL use NUM_DIGITS=1 with COMM[0] only and an index permanently 0; frame boundary = slot wrap.
REQ-023 SHALL never drive SEG low while COMM=0 in BLANK_CYCLES>0 configurations.

Reset
REQ-024 SHALL, when RST=1 at an edge, set slot counter=0, digit index=0, shadow=0, SEG=7'b1111111, COMM=0, ACK=0 and FRAME=0.
REQ-025 SHALL override LOAD with RST; a pending or in-progress capture is discarded and no ACK follows.
REQ-026 SHALL start digit 0's blank interval on the first cycle after RST deasserts, and SHALL emit no FRAME pulse for that first slot.

Configuration
REQ-027 SHALL, when macro HEX_LEADING_ZERO_BLANK_EN is defined, force SEG=7'b1111111 during the active portion of every digit above the most significant nonzero shadow nibble, while COMM still follows REQ-013.
REQ-028 SHALL never blank digit 0 under HEX_LEADING_ZERO_BLANK_EN, so a shadow value of 0 shows a single "0".
REQ-029 SHALL, when HEX_LEADING_ZERO_BLANK_EN is undefined, display all digits including zeros, and SHALL then contain no leading-zero logic.

Verification
Bench parameters: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
REQ-030 SHALL pass: reset, then DATA=16'h1234 with LOAD held -> ACK one cycle after the first frame wrap; thereafter COMM sequence 0001,0010,0100,1000 each active 6 of 8 cycles, with SEG 7'b0011001, 0110000, 0100100, 1111001 per digit.
REQ-031 SHALL pass: LOAD asserted mid-frame with DATA=16'hABCD, DATA changed to 16'hEF01 before the boundary -> shadow = 16'hEF01, with no digit showing a mixed value within any frame.
REQ-032 SHALL pass: LOAD=0 for 3 frames -> FRAME pulses every 32 cycles, ACK stays 0 and SEG is unchanged.
REQ-033 SHALL pass: RST pulsed while LOAD=1, one cycle before the boundary -> no ACK, SEG=7'b1111111 and COMM=0 the next cycle, shadow=0.
REQ-034 SHALL pass with HEX_LEADING_ZERO_BLANK_EN: DATA=16'h0040 -> digits 3 and 2 blank, digit 1 = 7'b0011001, digit 0 = 7'b1000000; without the macro, digits 3 and 2 = 7'b1000000.
REQ-035 SHALL pass a continuous check that COMM is one-hot-or-zero and that SEG=7'b1111111 whenever COMM=0 after reset.
